// File: rtl/wb_burst_master.sv
// Wishbone burst master: turns one request into up to MAX_BURST incrementing-address beats, with per-beat retry.
// Optional per-beat wait timeout is compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_burst_master #(
  parameter int TAGSIZE   = 2,
  parameter int MAX_BURST = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [3:0]         len_i,
  input  logic [TAGSIZE-1:0] tag_i,
  input  logic [31:0]        data_i,
  output logic               next_o,
  output logic [31:0]        data_o,
  output logic               rvalid_o,
  output logic               done_o,
  output logic               err_o,
  output logic [31:0]        wb_adr_o,
  output logic [31:0]        wb_dat_o,
  input  logic [31:0]        wb_dat_i,
  output logic               wb_we_o,
  output logic [3:0]         wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i,
  output logic [TAGSIZE-1:0] wb_tga_o,
  output logic [TAGSIZE-1:0] wb_tgc_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  input  logic [TAGSIZE-1:0] wb_tgd_i
);

  // state | meaning
  // IDLE  | ready_o high, waiting for valid_i
  // CYCLE | cyc/stb asserted, waiting for ack/err/rty on the current beat
  // RETRY | one-cycle bus release after rty, then same beat is reissued
  typedef enum logic [1:0] {IDLE, CYCLE, RETRY} state_t;

  localparam int             MAXB_I  = (MAX_BURST > 15) ? 15 : ((MAX_BURST < 1) ? 1 : MAX_BURST);
  localparam logic [3:0]     MAXB    = 4'(MAXB_I);
  localparam int             RW      = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0]  MAX_RTY = RW'(MAX_RETRY);

  state_t             state;
  logic [3:0]         beats_left;
  logic [RW-1:0]      retry_cnt;
  logic [TAGSIZE-1:0] tag_q;
  logic [3:0]         len_eff;
  logic               last_beat;
  logic               timeout_hit;
  logic               unused_tgd;

  assign unused_tgd = ^wb_tgd_i;

  assign ready_o   = (state == IDLE);
  assign last_beat = (beats_left == 4'd0);
  assign wb_tga_o  = tag_q;
  assign wb_tgc_o  = tag_q;
  assign wb_tgd_o  = tag_q;

  // Show-ahead handshake: upstream advances data_i on the same edge that latches it.
  assign next_o = (state == CYCLE) && wb_we_o && wb_ack_i && !wb_err_i && !last_beat;

  always_comb begin
    len_eff = len_i;
    if (len_i == 4'd0)
      len_eff = 4'd1;
    else if (len_i > MAXB)
      len_eff = MAXB;
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      wait_cnt <= TLOAD;
    else if (state != CYCLE || wb_ack_i || wb_err_i || wb_rty_i)
      wait_cnt <= TLOAD;
    else if (wait_cnt != '0)
      wait_cnt <= wait_cnt - TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      beats_left <= 4'd0;
      retry_cnt  <= '0;
      tag_q      <= '0;
      wb_adr_o   <= 32'd0;
      wb_dat_o   <= 32'd0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= 4'd0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      data_o     <= 32'd0;
      rvalid_o   <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            state      <= CYCLE;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_adr_o   <= addr_i;
            wb_dat_o   <= data_i;
            wb_we_o    <= we_i;
            wb_sel_o   <= sel_i;
            tag_q      <= tag_i;
            beats_left <= len_eff - 4'd1;
            retry_cnt  <= '0;
          end
        end
        CYCLE: begin
          if (wb_err_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
          end else if (wb_ack_i) begin
            if (!wb_we_o) begin
              data_o   <= wb_dat_i;
              rvalid_o <= 1'b1;
            end
            if (last_beat) begin
              state    <= IDLE;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              done_o   <= 1'b1;
            end else begin
              wb_adr_o   <= wb_adr_o + 32'd4;
              beats_left <= beats_left - 4'd1;
              retry_cnt  <= '0;
              if (wb_we_o)
                wb_dat_o <= data_i;
            end
          end else if (wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (retry_cnt < MAX_RTY) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= RETRY;
            end else begin
              state <= IDLE;
              err_o <= 1'b1;
            end
          end else if (timeout_hit) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
          end
        end
        RETRY: begin
          state    <= CYCLE;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: directed scenarios plus randomized bursts against a per-transaction model.
module tb_wb_burst_master;
  localparam int TAGSIZE   = 2;
  localparam int MAX_BURST = 8;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 255;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic valid_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0, wb_dat_i = '0;
  logic [3:0] sel_i = '0, len_i = '0;
  logic [TAGSIZE-1:0] tag_i = '0, wb_tgd_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic ready_o, next_o, rvalid_o, done_o, err_o;
  logic [31:0] data_o, wb_adr_o, wb_dat_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o;
  logic [3:0] wb_sel_o;
  logic [TAGSIZE-1:0] wb_tga_o, wb_tgc_o, wb_tgd_o;

  int n_cmp = 0;
  int n_bad = 0;

  // per-transaction plan consumed by do_txn
  logic [31:0] wdat [0:17];
  logic [31:0] rdat [0:17];
  int plan_wait [0:17];
  int plan_rty  [0:17];
  int plan_err;

  wb_burst_master #(.TAGSIZE(TAGSIZE), .MAX_BURST(MAX_BURST), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .we_i(we_i),
    .addr_i(addr_i), .sel_i(sel_i), .len_i(len_i), .tag_i(tag_i), .data_i(data_i),
    .next_o(next_o), .data_o(data_o), .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_tga_o(wb_tga_o), .wb_tgc_o(wb_tgc_o),
    .wb_tgd_o(wb_tgd_o), .wb_tgd_i(wb_tgd_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_plan();
    for (int i = 0; i < 18; i++) begin
      wdat[i] = $urandom; rdat[i] = $urandom; plan_wait[i] = 0; plan_rty[i] = 0;
    end
    plan_err = -1;
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [3:0] len, input logic [1:0] tag, input string nm);
    int eff, acked, retries, exp_next, exp_rv;
    int b, rtys, wl, widx, n_next, n_rv, n_drop, n_done, n_err;
    logic ok, fin, adv, exp_nx;
    logic [31:0] exp_adr;
    eff = (len == 0) ? 1 : ((int'(len) > MAX_BURST) ? MAX_BURST : int'(len));
    ok = 1'b1; acked = 0; retries = 0;
    for (int k = 0; k < eff; k++) begin
      if (plan_err == k) begin ok = 1'b0; break; end
      if (plan_rty[k] > MAX_RETRY) begin retries += MAX_RETRY; ok = 1'b0; break; end
      retries += plan_rty[k];
      acked++;
    end
    exp_next = !we ? 0 : (ok ? eff - 1 : acked);
    exp_rv   = we ? 0 : acked;

    @(negedge clk_i);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL %s ready_before: got %b want 1", nm, ready_o); end
    valid_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; len_i = len; tag_i = tag; data_i = wdat[0];
    @(negedge clk_i);
    data_i = wdat[1];
    b = 0; rtys = 0; wl = plan_wait[0]; widx = 1; fin = 0; adv = 0;
    n_next = 0; n_rv = 0; n_drop = 0; n_done = 0; n_err = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      // a busy-time request must be ignored
      valid_i = 1'(($urandom % 3) == 0); addr_i = $urandom; we_i = 1'($urandom); len_i = 4'($urandom);
      if (adv) begin widx++; data_i = wdat[widx]; adv = 0; end
      if (rvalid_o) begin
        n_cmp++;
        if (data_o !== rdat[n_rv]) begin n_bad++; $display("FAIL %s rdata[%0d]: got %h want %h", nm, n_rv, data_o, rdat[n_rv]); end
        n_rv++;
      end
      if (done_o) n_done++;
      if (err_o)  n_err++;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (done_o || err_o) begin
        fin = 1; valid_i = 0;
        n_cmp++;
        if ({ready_o, wb_cyc_o, wb_stb_o} !== 3'b100) begin n_bad++; $display("FAIL %s end_state: got rdy/cyc/stb %b want 100", nm, {ready_o, wb_cyc_o, wb_stb_o}); end
      end else if (wb_cyc_o && wb_stb_o) begin
        exp_adr = addr + 32'(4 * b);
        n_cmp++;
        if (wb_adr_o !== exp_adr) begin n_bad++; $display("FAIL %s adr beat%0d: got %h want %h", nm, b, wb_adr_o, exp_adr); end
        n_cmp++;
        if ({ready_o, wb_we_o, wb_sel_o, wb_tga_o, wb_tgc_o, wb_tgd_o} !== {1'b0, we, sel, tag, tag, tag}) begin
          n_bad++; $display("FAIL %s attrs: got rdy%b we%b sel%h tags %h/%h/%h want rdy0 we%b sel%h tag %h", nm,
                            ready_o, wb_we_o, wb_sel_o, wb_tga_o, wb_tgc_o, wb_tgd_o, we, sel, tag);
        end
        if (we) begin
          n_cmp++;
          if (wb_dat_o !== wdat[b]) begin n_bad++; $display("FAIL %s wdat beat%0d: got %h want %h", nm, b, wb_dat_o, wdat[b]); end
        end
        if (wl > 0) wl--;
        else if (plan_err == b) begin wb_err_i = 1; wb_ack_i = 1'($urandom); wb_rty_i = 1'($urandom); end
        else if (rtys < plan_rty[b]) begin wb_rty_i = 1; rtys++; end
        else begin wb_ack_i = 1; wb_rty_i = 1'($urandom); wb_dat_i = rdat[b]; end
        #1;
        exp_nx = we && wb_ack_i && !wb_err_i && (b < eff - 1);
        n_cmp++;
        if (next_o !== exp_nx) begin n_bad++; $display("FAIL %s next beat%0d: got %b want %b", nm, b, next_o, exp_nx); end
        if (next_o) begin n_next++; adv = 1; end
        if (wb_ack_i && !wb_err_i) begin b++; rtys = 0; wl = plan_wait[b]; end
      end else begin
        n_drop++;
        // responses while the bus is released must be ignored
        wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom); wb_rty_i = 1'($urandom);
      end
    end
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; valid_i = 0;
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL %s timeout: got no done/err want completion", nm); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      if (done_o) n_done++;
      if (err_o)  n_err++;
      wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
    end
    wb_ack_i = 0; wb_err_i = 0;
    n_cmp++;
    if ({n_done, n_err} !== {32'(ok), 32'(!ok)}) begin n_bad++; $display("FAIL %s outcome: got done%0d err%0d want done%0d err%0d", nm, n_done, n_err, ok, !ok); end
    n_cmp++;
    if (n_next !== exp_next) begin n_bad++; $display("FAIL %s next_count: got %0d want %0d", nm, n_next, exp_next); end
    n_cmp++;
    if (n_rv !== exp_rv) begin n_bad++; $display("FAIL %s rvalid_count: got %0d want %0d", nm, n_rv, exp_rv); end
    n_cmp++;
    if (n_drop !== retries) begin n_bad++; $display("FAIL %s cyc_drops: got %0d want %0d", nm, n_drop, retries); end
    n_cmp++;
    if (b !== acked) begin n_bad++; $display("FAIL %s beats_acked: got %0d want %0d", nm, b, acked); end
  endtask

  task automatic test_reset();
    rst_i = 0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, next_o, rvalid_o, done_o, err_o} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 0000000", {wb_cyc_o, wb_stb_o, wb_we_o, next_o, rvalid_o, done_o, err_o});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, data_o, wb_sel_o, wb_tga_o, wb_tgc_o, wb_tgd_o} !== '0) begin
      n_bad++; $display("FAIL reset_data: got adr %h dat %h do %h sel %h want all 0", wb_adr_o, wb_dat_o, data_o, wb_sel_o);
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rst_i = 1;
  endtask

  task automatic test_directed();
    clear_plan(); plan_wait[0] = 1; rdat[0] = 32'hDEADBEEF;
    do_txn(1'b0, 32'h100, 4'hF, 4'd1, 2'd1, "single_read");
    n_cmp++;
    if (data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_read_data: got %h want deadbeef", data_o); end
    clear_plan(); wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
    do_txn(1'b1, 32'h1000, 4'h3, 4'd4, 2'd2, "write_burst");
    clear_plan(); plan_rty[1] = 2;
    do_txn(1'b0, 32'h0, 4'hF, 4'd3, 2'd0, "retry_twice");
    clear_plan(); plan_rty[1] = 4;
    do_txn(1'b0, 32'h0, 4'hF, 4'd3, 2'd3, "retry_exhaust");
    clear_plan(); plan_err = 0;
    do_txn(1'b1, 32'h80, 4'hF, 4'd4, 2'd1, "err_priority");
    clear_plan();
    do_txn(1'b0, 32'hFFFFFFFC, 4'hF, 4'd2, 2'd2, "addr_wrap");
    clear_plan();
    do_txn(1'b1, 32'h200, 4'h1, 4'd0, 2'd0, "len_zero");
    clear_plan();
    do_txn(1'b0, 32'h300, 4'hF, 4'd12, 2'd3, "len_clamp");
  endtask

  task automatic test_reset_midburst();
    bit seen;
    clear_plan();
    @(negedge clk_i);
    valid_i = 1; we_i = 1; addr_i = 32'h2000; sel_i = 4'hF; len_i = 4'd4; tag_i = 2'd1; data_i = 32'h1111;
    @(negedge clk_i);
    valid_i = 0; data_i = 32'h2222; wb_ack_i = 1;
    @(negedge clk_i);
    wb_ack_i = 0;
    n_cmp++;
    if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h2004}) begin n_bad++; $display("FAIL midburst_beat2: got cyc%b adr %h want cyc1 adr 2004", wb_cyc_o, wb_adr_o); end
    #2 rst_i = 0;
    #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, ready_o, wb_adr_o, wb_dat_o} !== {4'b0001, 64'd0}) begin
      n_bad++; $display("FAIL midburst_reset: got cyc%b stb%b we%b rdy%b adr %h dat %h want 0001 0 0", wb_cyc_o, wb_stb_o, wb_we_o, ready_o, wb_adr_o, wb_dat_o);
    end
    seen = 0;
    repeat (2) begin @(negedge clk_i); if (done_o || err_o) seen = 1; end
    valid_i = 1; we_i = 0; addr_i = 32'h300; len_i = 4'd1; tag_i = 2'd2; rst_i = 1;
    @(posedge clk_i); #1;
    n_cmp++;
    if ({wb_cyc_o, wb_adr_o, wb_tga_o} !== {1'b1, 32'h300, 2'd2}) begin n_bad++; $display("FAIL first_accept: got cyc%b adr %h tag %h want cyc1 adr 300 tag 2", wb_cyc_o, wb_adr_o, wb_tga_o); end
    @(negedge clk_i);
    if (done_o || err_o) seen = 1;
    valid_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D;
    @(negedge clk_i);
    wb_ack_i = 0;
    n_cmp++;
    if ({done_o, err_o, rvalid_o, data_o} !== {3'b101, 32'hCAFEF00D}) begin n_bad++; $display("FAIL after_reset_read: got done%b err%b rv%b data %h want 101 cafef00d", done_o, err_o, rvalid_o, data_o); end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL midburst_no_pulse: got done/err pulse want none"); end
  endtask

  task automatic test_wait_limit();
    int cnt;
    bit got_err;
    @(negedge clk_i);
    valid_i = 1; we_i = 0; addr_i = 32'h40; len_i = 4'd1; tag_i = 2'd0;
    @(negedge clk_i);
    valid_i = 0; cnt = 0; got_err = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 1000 && !got_err; i++) begin
      if (err_o) got_err = 1;
      else if (wb_cyc_o) cnt++;
      if (!got_err) @(negedge clk_i);
    end
    n_cmp++;
    if ({got_err, cnt} !== {1'b1, 32'(TIMEOUT)}) begin n_bad++; $display("FAIL timeout_err: got err%b after %0d cycles want err1 after %0d", got_err, cnt, TIMEOUT); end
`else
    for (int i = 0; i < 300; i++) begin
      if (err_o || done_o) got_err = 1;
      if (wb_cyc_o) cnt++;
      @(negedge clk_i);
    end
    n_cmp++;
    if ({got_err, cnt} !== {1'b0, 32'd300}) begin n_bad++; $display("FAIL wait_forever: got pulse%b cyc_cycles %0d want 0 300", got_err, cnt); end
    wb_ack_i = 1; wb_dat_i = 32'h5A5A;
    @(negedge clk_i);
    wb_ack_i = 0;
    n_cmp++;
    if ({done_o, err_o} !== 2'b10) begin n_bad++; $display("FAIL wait_then_ack: got done%b err%b want 10", done_o, err_o); end
`endif
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 40; t++) begin
      clear_plan();
      for (int k = 0; k < 16; k++) begin
        plan_wait[k] = $urandom_range(0, 2);
        plan_rty[k]  = (($urandom % 4) == 0) ? $urandom_range(1, 4) : 0;
      end
      if (($urandom % 5) == 0) plan_err = $urandom_range(0, 7);
      a = (($urandom % 4) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFFFFFC);
      do_txn(1'($urandom), a, 4'($urandom), 4'($urandom), 2'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midburst();
    test_wait_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter TAGSIZE, default 2, width of all Wishbone tag ports.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum beats per transaction.
REQ-003 SHALL have parameter MAX_RETRY, default 3, retries tolerated per beat before abort.
REQ-004 SHALL have parameter TIMEOUT, default 255, wait cycles per beat before abort (used only with the macro in REQ-031).
REQ-005 Clock: clk_i, in, 1, single clock, rising edge.
REQ-006 Reset: rst_i, in, 1, asynchronous and active-low.
REQ-007 Request port: valid_i in 1 request; ready_o out 1 idle/accepting; we_i in 1 write; addr_i in 32 start byte address; sel_i in 4 byte select; len_i in 4 beat count; tag_i in TAGSIZE tag.
REQ-008 Data port: data_i in 32 write word, show-ahead; next_o out 1 write word consumed; data_o out 32 read word; rvalid_o out 1 read word valid; done_o out 1 transaction ok; err_o out 1 transaction aborted.
REQ-009 Wishbone port: wb_adr_o out 32; wb_dat_o out 32; wb_dat_i in 32; wb_we_o out 1; wb_sel_o out 4; wb_cyc_o out 1; wb_stb_o out 1; wb_ack_i, wb_err_i, wb_rty_i in 1 each; wb_tga_o, wb_tgc_o, wb_tgd_o out TAGSIZE; wb_tgd_i in TAGSIZE.

Function
REQ-010 FSM states SHALL be IDLE, CYCLE, RETRY.
REQ-011 ready_o SHALL be 1 exactly when in IDLE; a request is accepted when valid_i && ready_o.
REQ-012 On accept: latch addr_i, we_i, sel_i, tag_i, and data_i into wb_dat_o; effective len = 1 if len_i==0, MAX_BURST if len_i>MAX_BURST, else len_i; go to CYCLE next cycle.
REQ-013 In CYCLE, wb_cyc_o and wb_stb_o SHALL be 1; all other wb outputs registered and stable until ack/err/rty.
REQ-014 wb_tga_o, wb_tgc_o, and wb_tgd_o SHALL all carry the latched tag.
REQ-015 On wb_ack_i for a non-last beat: wb_adr_o += 4 (modulo 2^32, 0xFFFFFFFC wraps to 0x0); beat counter +1; retry counter cleared; stay in CYCLE.
REQ-016 On wb_ack_i for a non-last write beat: next_o=1 that cycle, and wb_dat_o <= data_i at the same edge; upstream presents the next word on data_i show-ahead.
REQ-017 On wb_ack_i during a read: data_o <= wb_dat_i, rvalid_o=1 for one cycle (registered, the cycle after ack).
REQ-018 On wb_ack_i for the last beat: go to IDLE; done_o pulses 1 cycle; cyc/stb deassert next cycle.
REQ-019 On wb_err_i in CYCLE: go to IDLE; err_o pulses 1 cycle; remaining beats dropped.
REQ-020 wb_err_i SHALL take priority over wb_ack_i and wb_rty_i when asserted together; wb_ack_i SHALL take priority over wb_rty_i.
REQ-021 On wb_rty_i: if the retry counter < MAX_RETRY, increment it and go to RETRY; otherwise go to IDLE and pulse err_o.
REQ-022 In RETRY, wb_cyc_o=wb_stb_o=0 for exactly one cycle, then return to CYCLE with the same address and data.
REQ-023 Bus responses SHALL be ignored outside CYCLE.
REQ-024 done_o and err_o SHALL be mutually exclusive; exactly one of them pulses per accepted request.
REQ-025 valid_i while not ready SHALL be ignored; no request queueing.

Reset
REQ-026 Assertion of rst_i SHALL immediately force IDLE.
REQ-027 On reset assertion, wb_cyc_o, wb_stb_o, wb_we_o, next_o, rvalid_o, done_o, and err_o SHALL go to 0, including mid-burst; no done/err pulse follows.
REQ-028 On reset assertion, wb_adr_o, wb_dat_o, data_o, wb_sel_o, and the tag outputs SHALL go to 0, and ready_o to 1.
REQ-029 All counters SHALL clear on reset.
REQ-030 The first accept SHALL be possible on the first rising edge after deassertion.

Configuration
REQ-031 Macro WB_MASTER_TIMEOUT_EN defined: a per-beat wait counter runs in CYCLE and clears on ack/rty. After TIMEOUT cycles without ack, err, or rty, the FSM SHALL go to IDLE and pulse err_o.
REQ-032 Macro undefined: no wait counter exists; CYCLE waits indefinitely.

Verification
REQ-033 Single read, addr 0x100, len 1, ack on the 2nd CYCLE clock with wb_dat_i=0xDEADBEEF -> data_o=0xDEADBEEF, rvalid_o pulse, done_o pulse, ready_o=1.
REQ-034 Write burst, len 4, addr 0x1000, data stream A,B,C,D, ack every cycle -> wb_adr_o 0x1000/4/8/C, wb_dat_o A..D, 3 next_o pulses, one done_o.
REQ-035 Read len 3 with wb_rty_i on beat 2 twice, then ack -> two 1-cycle cyc drops, same address 0x4, done_o; a 4th rty on a beat -> err_o.
REQ-036 Simultaneous ack+err on beat 1 of 4 -> err_o only, no done_o, back to IDLE; start address 0xFFFFFFFC len 2 -> second beat at 0x0.
REQ-037 rst_i low mid-burst on beat 2 -> cyc/stb 0 immediately, no done/err; with WB_MASTER_TIMEOUT_EN and TIMEOUT=255, no response -> err_o after 255 CYCLE cycles.
